// File: rtl/video_dram_arb_if.sv
// Request/grant bundle between the video-side DRAM clients and the slot arbiter.
// The master modport is the requester side and the slave modport is the arbiter.
interface video_dram_arb_if #(
    parameter int AW = 21
);
    logic          video_go;
    logic [4:0]    video_bw;
    logic [AW-1:0] video_addr;
    logic          tm_req;
    logic [AW-1:0] tm_addr;
    logic          ts_req;
    logic [AW-1:0] ts_addr;
    logic          ts_z80_lp;
    logic          cpu_req;
    logic          cpu_rnw;
    logic [AW-1:0] cpu_addr;

    logic          dram_req;
    logic          dram_rnw;
    logic [AW-1:0] dram_addr;
    logic          video_pre_next;
    logic          ts_pre_next;
    logic          video_next;
    logic          tm_next;
    logic          ts_next;
    logic          cpu_next;
    logic          video_strobe;
    logic          cpu_strobe;

    modport master (
        output video_go, video_bw, video_addr, tm_req, tm_addr, ts_req, ts_addr,
               ts_z80_lp, cpu_req, cpu_rnw, cpu_addr,
        input  dram_req, dram_rnw, dram_addr, video_pre_next, ts_pre_next,
               video_next, tm_next, ts_next, cpu_next, video_strobe, cpu_strobe
    );

    modport slave (
        input  video_go, video_bw, video_addr, tm_req, tm_addr, ts_req, ts_addr,
               ts_z80_lp, cpu_req, cpu_rnw, cpu_addr,
        output dram_req, dram_rnw, dram_addr, video_pre_next, ts_pre_next,
               video_next, tm_next, ts_next, cpu_next, video_strobe, cpu_strobe
    );
endinterface

// File: rtl/video_dram_arb.sv
// Four-clock DRAM slot arbiter: video gets a guaranteed slot budget per window,
// leftover slots go to tilemap, then TS/Z80 in a selectable order.
module video_dram_arb #(
    parameter int SLOTS_LOG2 = 3,
    parameter int AW         = 21
) (
    input  logic clk,
    input  logic res,
    video_dram_arb_if.slave bus
);
    localparam int VCW = SLOTS_LOG2 + 1;
    localparam int WIN = 1 << SLOTS_LOG2;

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_VIDEO,
        OWN_TM,
        OWN_TS,
        OWN_CPU
    } owner_t;

    logic [1:0]            ph;
    logic [SLOTS_LOG2-1:0] sl;
    logic [VCW-1:0]        vc;
    logic [VCW-1:0]        vc_eff;
    logic [VCW-1:0]        budget;
    logic [3:0]            bw_lo;
    logic                  video_elig;
    owner_t                owner;
    owner_t                owner_nxt;
    owner_t                win;
    logic [AW-1:0]         win_addr;
    logic [AW-1:0]         addr_nxt;
    logic                  win_rnw;
    logic                  rnw_nxt;

    // Bit 4 of the bandwidth field is reserved and masked away here.
    assign bw_lo = 4'(bus.video_bw & 5'h0F);

    always_comb begin
        if ({1'b0, bw_lo} > 5'(WIN)) budget = VCW'(WIN);
        else                         budget = VCW'(bw_lo);
    end

    // The window-wrap clear must be visible to the slot-0 eligibility check.
    assign vc_eff     = (&sl) ? '0 : vc;
    assign video_elig = bus.video_go && (vc_eff < budget);

    always_comb begin
        win      = OWN_NONE;
        win_addr = bus.cpu_addr;
        win_rnw  = 1'b1;
        if (video_elig) begin
            win      = OWN_VIDEO;
            win_addr = bus.video_addr;
        end else if (bus.tm_req) begin
            win      = OWN_TM;
            win_addr = bus.tm_addr;
        end else if (bus.ts_z80_lp && bus.cpu_req) begin
            win      = OWN_CPU;
            win_addr = bus.cpu_addr;
            win_rnw  = bus.cpu_rnw;
        end else if (bus.ts_req) begin
            win      = OWN_TS;
            win_addr = bus.ts_addr;
        end else if (bus.cpu_req) begin
            win      = OWN_CPU;
            win_addr = bus.cpu_addr;
            win_rnw  = bus.cpu_rnw;
        end
    end

    always_ff @(posedge clk) begin
        if (ph == 2'd2) begin
            addr_nxt <= win_addr;
            rnw_nxt  <= win_rnw;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ph                 <= 2'd0;
            sl                 <= '0;
            vc                 <= '0;
            owner              <= OWN_NONE;
            owner_nxt          <= OWN_NONE;
            bus.dram_req       <= 1'b0;
            bus.dram_rnw       <= 1'b0;
            bus.dram_addr      <= '0;
            bus.video_pre_next <= 1'b0;
            bus.ts_pre_next    <= 1'b0;
            bus.video_next     <= 1'b0;
            bus.tm_next        <= 1'b0;
            bus.ts_next        <= 1'b0;
            bus.cpu_next       <= 1'b0;
            bus.video_strobe   <= 1'b0;
            bus.cpu_strobe     <= 1'b0;
        end else begin
            ph                 <= ph + 2'd1;
            bus.dram_req       <= 1'b0;
            bus.video_pre_next <= 1'b0;
            bus.ts_pre_next    <= 1'b0;
            bus.video_next     <= 1'b0;
            bus.tm_next        <= 1'b0;
            bus.ts_next        <= 1'b0;
            bus.cpu_next       <= 1'b0;
            bus.video_strobe   <= 1'b0;
            bus.cpu_strobe     <= 1'b0;
            case (ph)
                // Entering phase 3: pick the next owner, raise strobes for the current one.
                2'd2: begin
                    owner_nxt          <= win;
                    vc                 <= vc_eff + VCW'(win == OWN_VIDEO);
                    bus.video_pre_next <= (win == OWN_VIDEO);
                    bus.ts_pre_next    <= (win == OWN_TS);
                    bus.video_strobe   <= (owner == OWN_VIDEO);
                    bus.cpu_strobe     <= (owner == OWN_CPU) && bus.dram_rnw;
                end
                // Entering phase 0: start the DRAM cycle for the arbitrated owner.
                2'd3: begin
                    sl             <= sl + SLOTS_LOG2'(1);
                    owner          <= owner_nxt;
                    bus.dram_req   <= (owner_nxt != OWN_NONE);
                    bus.video_next <= (owner_nxt == OWN_VIDEO);
                    bus.tm_next    <= (owner_nxt == OWN_TM);
                    bus.ts_next    <= (owner_nxt == OWN_TS);
                    bus.cpu_next   <= (owner_nxt == OWN_CPU);
                    if (owner_nxt != OWN_NONE) begin
                        bus.dram_addr <= addr_nxt;
                        bus.dram_rnw  <= rnw_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_video_dram_arb.sv
// Directed slot-by-slot bench for video_dram_arb; each slot is checked at all
// four phases against hand-chosen expected owners.
module tb_video_dram_arb;
    localparam int AW  = 21;
    localparam int N   = 0;
    localparam int V   = 1;
    localparam int TM  = 2;
    localparam int TS  = 3;
    localparam int CPU = 4;

    logic clk = 1'b0;
    logic res;
    int   total;
    int   bad;
    int   slot;
    int   prev;
    logic prev_rnw;
    logic [AW:0] last_ra;
    logic [8:0]  outs;

    always #5 clk = ~clk;

    video_dram_arb_if #(.AW(AW)) bus ();

    video_dram_arb #(.SLOTS_LOG2(3), .AW(AW)) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    assign outs = {bus.dram_req, bus.video_next, bus.tm_next, bus.ts_next, bus.cpu_next,
                   bus.video_pre_next, bus.ts_pre_next, bus.video_strobe, bus.cpu_strobe};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at phase 2 of the previous slot; walks ph3 of that slot and ph0..2 of the next.
    task automatic slot_is(input int own);
        logic [8:0]  e;
        logic [AW:0] ra;
        slot++;
        bus.video_addr = AW'(32'h100 + slot);
        case (own)
            V:       ra = {1'b1, bus.video_addr};
            TM:      ra = {1'b1, bus.tm_addr};
            TS:      ra = {1'b1, bus.ts_addr};
            CPU:     ra = {bus.cpu_rnw, bus.cpu_addr};
            default: ra = last_ra;
        endcase
        tick();
        e    = '0;
        e[3] = (own == V);
        e[2] = (own == TS);
        e[1] = (prev == V);
        e[0] = (prev == CPU) && prev_rnw;
        chk($sformatf("s%0d_ph3", slot), 32'(outs), 32'(e));
        tick();
        e    = '0;
        e[8] = (own != N);
        e[7] = (own == V);
        e[6] = (own == TM);
        e[5] = (own == TS);
        e[4] = (own == CPU);
        chk($sformatf("s%0d_ph0", slot), 32'(outs), 32'(e));
        chk($sformatf("s%0d_addr", slot), 32'({bus.dram_rnw, bus.dram_addr}), 32'(ra));
        tick();
        chk($sformatf("s%0d_ph1", slot), 32'(outs), 32'd0);
        tick();
        chk($sformatf("s%0d_ph2", slot), 32'(outs), 32'd0);
        last_ra  = ra;
        prev     = own;
        prev_rnw = ra[AW];
    endtask

    initial begin
        #200000;
        $display("FAIL timeout slot=%0d", slot);
        $fatal(1, "timeout");
    end

    initial begin
        total = 0; bad = 0; slot = 0; prev = N; prev_rnw = 1'b1; last_ra = '0;
        bus.video_go = 1'b0; bus.video_bw = 5'd0; bus.video_addr = '0;
        bus.tm_req = 1'b0; bus.tm_addr = 21'h0AAAA;
        bus.ts_req = 1'b0; bus.ts_addr = 21'h15555; bus.ts_z80_lp = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_rnw = 1'b1; bus.cpu_addr = 21'h0C0DE;
        res = 1'b0;
        #2 res = 1'b1;
        #1;
        chk("rst_outs", 32'(outs), 32'd0);
        chk("rst_addr", 32'({bus.dram_rnw, bus.dram_addr}), 32'd0);
        bus.video_go = 1'b1; bus.video_bw = 5'd4; bus.tm_req = 1'b1; bus.cpu_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", 32'(outs), 32'd0);
        bus.video_go = 1'b0; bus.video_bw = 5'd0; bus.tm_req = 1'b0; bus.cpu_req = 1'b0;
        @(negedge clk) res = 1'b0;
        tick();
        tick();

        // Idle window, then video budget of 4 over two windows.
        for (int s = 1; s < 8; s++) slot_is(N);
        bus.video_go = 1'b1; bus.video_bw = 5'd4;
        for (int s = 8; s < 24; s++) slot_is(((s % 8) < 4) ? V : N);

        // Video + tm + ts + cpu, cpu write pending: rnw forced to read for others.
        bus.tm_req = 1'b1; bus.ts_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b0;
        for (int s = 24; s < 32; s++) slot_is(((s % 8) < 4) ? V : TM);
        bus.tm_req = 1'b0;
        for (int s = 32; s < 40; s++) slot_is(((s % 8) < 4) ? V : TS);

        // ts_z80_lp swaps TS/Z80 order from the next arbitration.
        bus.video_go = 1'b0; bus.ts_z80_lp = 1'b1; bus.cpu_rnw = 1'b1;
        for (int s = 40; s < 44; s++) slot_is(CPU);
        bus.ts_z80_lp = 1'b0;
        for (int s = 44; s < 48; s++) slot_is(TS);

        // Bandwidth 15 (bit 4 set too) clamps to 8; drop video_go mid-window.
        bus.ts_req = 1'b0; bus.cpu_req = 1'b0; bus.tm_req = 1'b1;
        bus.video_go = 1'b1; bus.video_bw = 5'h1F;
        for (int s = 48; s < 56; s++) slot_is(V);
        for (int s = 56; s < 64; s++) begin
            if (s == 60) bus.video_go = 1'b0;
            slot_is((s < 60) ? V : TM);
        end

        // Budget 0 (reserved bit ignored), then raise to 2 mid-window.
        bus.tm_req = 1'b0; bus.video_go = 1'b1; bus.video_bw = 5'h10;
        for (int s = 64; s < 68; s++) slot_is(N);
        bus.video_bw = 5'h02;
        for (int s = 68; s < 72; s++) slot_is((s < 70) ? V : N);

        // Z80 write: no strobe, address held through the following idle slot.
        bus.video_go = 1'b0; bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_addr = 21'h1ABCD;
        slot_is(CPU);
        bus.cpu_req = 1'b0;
        slot_is(N);

        // Reset pulse during phase 2 of a video slot.
        bus.video_go = 1'b1; bus.video_bw = 5'h08;
        slot_is(V);
        res = 1'b1;
        #1;
        chk("rst_async_outs", 32'(outs), 32'd0);
        chk("rst_async_addr", 32'({bus.dram_rnw, bus.dram_addr}), 32'd0);
        #1 res = 1'b0;
        slot = 0; prev = N; prev_rnw = 1'b1; last_ra = '0;
        tick();
        chk("rst_nostrobe", 32'(outs), 32'd0);
        tick();
        slot_is(V);
        slot_is(V);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
